// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive engine.
//
// Samples the asynchronous serial line `rx` with an oversampling clock `baud`
// (OVERSAMPLE ticks per bit), recovers LSB-first 8-bit frames and presents
// each good byte in a holding register with a valid/acknowledge handshake.
//
// Ports:
//   baud        in   oversampling clock, all logic on the rising edge
//   reset       in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to baud
//   data_ack    in   host consumed `data`; clears `data_ready`
//   data        out  last correctly framed byte (bit 0 received first)
//   data_ready  out  a byte is held and not yet acknowledged
//   data_st     out  one-cycle pulse when a good frame loads `data`
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   overrun     out  one-cycle pulse when a good frame overwrites an unacked byte
//   busy        out  receiver is anywhere but IDLE
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       baud,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       data_st,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  // Tick value at mid-start-bit and at the end of a full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

  logic [1:0]       rx_sync_q;
  logic             rx_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  logic             good_stop_s;
  logic             bad_stop_s;

  logic [7:0]       data_q, data_d;
  logic             data_ready_q, data_ready_d;
  logic             data_st_q, data_st_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous rx pin; resets to idle-high.
  always_ff @(posedge baud or negedge reset) begin
    if (!reset) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
    end
  end

  assign rx_s = rx_sync_q[1];

  // Receiver state, tick counter, bit index and shift register.
  always_ff @(posedge baud or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: start detection, mid-bit sampling and stop decision.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    good_stop_s = 1'b0;
    bad_stop_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        // Re-check the line half a bit in; a high line means a glitch.
        if (tick_q == HALF_LAST) begin
          if (!rx_s) begin
            state_d   = S_DATA;
            tick_d    = '0;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        // Counting starts mid-start-bit, so a full period lands mid-data-bit.
        if (tick_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          tick_d             = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (tick_q == BIT_LAST) begin
          if (rx_s) begin
            good_stop_s = 1'b1;
            state_d     = S_IDLE;
          end else begin
            bad_stop_s = 1'b1;
            state_d    = S_RECOVER;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_RECOVER: begin
        // Stay here while the line is held low so a break never looks like a start bit.
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECOVER;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register, handshake and status pulses.
  always_comb begin
    data_d       = data_q;
    data_ready_d = data_ready_q;
    data_st_d    = good_stop_s;
    frame_err_d  = bad_stop_s;
    overrun_d    = 1'b0;

    if (good_stop_s) begin
      data_d       = shift_q;
      data_ready_d = 1'b1;
      // An ack in the same cycle consumes the old byte, so nothing is lost.
      overrun_d    = data_ready_q & ~data_ack;
    end else if (data_ack) begin
      data_ready_d = 1'b0;
    end else begin
      data_ready_d = data_ready_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Registered outputs.
  always_ff @(posedge baud or negedge reset) begin
    if (!reset) begin
      data_q       <= 8'h00;
      data_ready_q <= 1'b0;
      data_st_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      data_st_q    <= data_st_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign data_ready = data_ready_q;
  assign data_st    = data_st_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver.
// A timeline model derives every output from the history of the line as the
// receiver sees it (pin delayed two edges) and from sample instants measured
// relative to the start edge. Directed literal checks pin the model.
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int STOP_REL = OS / 2 + 9 * OS;

  logic       baud = 1'b0;
  logic       reset;
  logic       rx;
  logic       data_ack;
  logic [7:0] data;
  logic       data_ready;
  logic       data_st;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int ack_at   = -10;
  bit ack_rand = 1'b0;
  int frame_k  = 0;

  int st_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int last_st_cyc = -1, last_fe_cyc = -1, last_ov_cyc = -1;
  int         st_cyc_log[$];
  logic [7:0] st_dat_log[$];

  // model state
  logic m_d1 = 1'b1, m_d2 = 1'b1;
  int   m_mode = 0;  // 0 idle, 1 in frame, 2 waiting for line high
  int   m_rel  = 0;
  bit   m_hist [0:STOP_REL];
  logic [7:0] m_data = 8'h00;
  logic m_ready = 1'b0, m_st = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_busy = 1'b0;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .baud       (baud),
    .reset      (reset),
    .rx         (rx),
    .data_ack   (data_ack),
    .data       (data),
    .data_ready (data_ready),
    .data_st    (data_st),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial forever #5 baud = ~baud;

  always @(posedge baud) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one step per edge, using the value visible two edges after the pin.
  initial begin
    logic       s;
    logic       good;
    logic [7:0] b;
    forever begin
      @(posedge baud or negedge reset);
      if (reset !== 1'b1) begin
        m_d1 = 1'b1; m_d2 = 1'b1; m_mode = 0; m_rel = 0;
        m_data = 8'h00; m_ready = 1'b0; m_st = 1'b0; m_fe = 1'b0;
        m_ov = 1'b0; m_busy = 1'b0;
      end else begin
        s = m_d2; m_d2 = m_d1; m_d1 = rx;
        good = 1'b0; m_st = 1'b0; m_fe = 1'b0; m_ov = 1'b0; b = 8'h00;
        if (m_mode == 0) begin
          if (!s) begin m_mode = 1; m_rel = 0; end
        end else if (m_mode == 1) begin
          m_rel++;
          m_hist[m_rel] = s;
          if (m_rel == OS / 2 && s) begin
            m_mode = 0;
          end else if (m_rel == STOP_REL) begin
            for (int n = 0; n < 8; n++) b[n] = m_hist[OS / 2 + (n + 1) * OS];
            if (s) begin good = 1'b1; m_mode = 0; end
            else begin m_fe = 1'b1; m_mode = 2; end
          end
        end else begin
          if (s) m_mode = 0;
        end
        if (good) begin
          m_ov    = m_ready && !data_ack;
          m_data  = b;
          m_ready = 1'b1;
          m_st    = 1'b1;
        end else if (data_ack) begin
          m_ready = 1'b0;
        end
        m_busy = (m_mode != 0);
      end
    end
  end

  // Compare process: every falling edge, DUT against model; also logs pulses.
  initial forever begin
    @(negedge baud);
    check("data",       {24'd0, data},      {24'd0, m_data});
    check("data_ready", {31'd0, data_ready}, {31'd0, m_ready});
    check("data_st",    {31'd0, data_st},    {31'd0, m_st});
    check("frame_err",  {31'd0, frame_err},  {31'd0, m_fe});
    check("overrun",    {31'd0, overrun},    {31'd0, m_ov});
    check("busy",       {31'd0, busy},       {31'd0, m_busy});
    if (data_st === 1'b1) begin
      st_cnt++; last_st_cyc = cyc;
      st_cyc_log.push_back(cyc); st_dat_log.push_back(data);
    end
    if (frame_err === 1'b1) begin fe_cnt++; last_fe_cyc = cyc; end
    if (overrun === 1'b1)   begin ov_cnt++; last_ov_cyc = cyc; end
  end

  // Ack driver: a scheduled single-cycle ack and/or random acks.
  initial begin
    data_ack = 1'b0;
    forever begin
      @(negedge baud); #1;
      data_ack = (cyc == ack_at) || (ack_rand && ($urandom_range(0, 3) == 0));
    end
  end

  task automatic hold(input logic v, input int n);
    if (n > 0) begin
      @(negedge baud); #1;
      rx = v;
      repeat (n - 1) @(negedge baud);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input logic ack_stop);
    @(negedge baud); #1;
    frame_k = cyc;
    rx = 1'b0;
    if (ack_stop) ack_at = frame_k + 154;
    repeat (OS - 1) @(negedge baud);
    for (int i = 0; i < 8; i++) hold(b[i], OS);
    hold(stop_v, OS);
  endtask

  task automatic ack_now();
    ack_at = cyc + 1;
    repeat (3) @(negedge baud);
  endtask

  initial begin
    int k, s0, f0, o0, n;
    logic [7:0] rb;
    reset = 1'b0;
    rx    = 1'b1;

    // reset state
    repeat (5) @(negedge baud);
    check("rst_data",  {24'd0, data}, 32'h00);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_st",    {31'd0, data_st}, 32'd0);
    check("rst_fe",    {31'd0, frame_err}, 32'd0);
    check("rst_ov",    {31'd0, overrun}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    #1 reset = 1'b1;
    hold(1'b1, 100);
    check("idle_pulses", st_cnt + fe_cnt + ov_cnt, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // single frame 0xA5
    send(8'hA5, 1'b1, 1'b0);
    k = frame_k;
    hold(1'b1, 5);
    check("a5_st_cycle", last_st_cyc, k + 155);
    check("a5_st_count", st_cnt, 32'd1);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_ready", {31'd0, data_ready}, 32'd1);
    ack_now();
    check("a5_acked", {31'd0, data_ready}, 32'd0);

    // back-to-back 0x00, 0xFF
    s0 = st_cnt;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 5);
    n = st_cyc_log.size();
    check("b2b_count", st_cnt, s0 + 2);
    if (n >= 2) begin
      check("b2b_spacing", st_cyc_log[n-1] - st_cyc_log[n-2], 32'd160);
      check("b2b_first",  {24'd0, st_dat_log[n-2]}, 32'h00);
      check("b2b_second", {24'd0, st_dat_log[n-1]}, 32'hFF);
    end else begin
      check("b2b_logged", n, 32'd2);
    end
    ack_now();

    // glitch: 4 cycles low
    s0 = st_cnt; f0 = fe_cnt;
    @(negedge baud); #1;
    k = cyc; rx = 1'b0;
    repeat (3) @(negedge baud);
    hold(1'b1, 1);
    while (cyc < k + 11) @(negedge baud);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    hold(1'b1, 20);
    check("glitch_pulses", (st_cnt - s0) + (fe_cnt - f0), 32'd0);

    // framing error + break, then recovery with 0x12
    f0 = fe_cnt;
    send(8'h3C, 1'b0, 1'b0);
    k = frame_k;
    hold(1'b0, 50);
    check("fe_cycle", last_fe_cyc, k + 155);
    check("fe_count", fe_cnt, f0 + 1);
    check("fe_data_kept", {24'd0, data}, 32'hFF);
    check("fe_ready_kept", {31'd0, data_ready}, 32'd0);
    check("break_busy", {31'd0, busy}, 32'd1);
    hold(1'b1, 20);
    check("break_released", {31'd0, busy}, 32'd0);
    send(8'h12, 1'b1, 1'b0);
    hold(1'b1, 5);
    check("after_break_data", {24'd0, data}, 32'h12);
    ack_now();

    // overrun
    o0 = ov_cnt;
    send(8'h11, 1'b1, 1'b0);
    hold(1'b1, 3);
    send(8'h22, 1'b1, 1'b0);
    hold(1'b1, 5);
    check("ov_count", ov_cnt, o0 + 1);
    check("ov_with_st", last_ov_cyc, last_st_cyc);
    check("ov_data", {24'd0, data}, 32'h22);
    check("ov_ready", {31'd0, data_ready}, 32'd1);
    ack_now();

    // ack on the stop-decision cycle: no overrun
    send(8'h33, 1'b1, 1'b0);
    hold(1'b1, 3);
    o0 = ov_cnt;
    send(8'h44, 1'b1, 1'b1);
    k = frame_k;
    hold(1'b1, 5);
    check("ackstop_st_cycle", last_st_cyc, k + 155);
    check("ackstop_no_ov", ov_cnt, o0);
    check("ackstop_data", {24'd0, data}, 32'h44);
    check("ackstop_ready", {31'd0, data_ready}, 32'd1);

    // reset during data bit 4
    rb = 8'hE7;
    @(negedge baud); #1;
    rx = 1'b0;
    repeat (OS - 1) @(negedge baud);
    for (int i = 0; i < 4; i++) hold(rb[i], OS);
    hold(rb[4], OS / 2);
    @(negedge baud); #1;
    reset = 1'b0; rx = 1'b1;
    #1;
    check("mrst_data",  {24'd0, data}, 32'h00);
    check("mrst_ready", {31'd0, data_ready}, 32'd0);
    check("mrst_pulses", {29'd0, data_st, frame_err, overrun}, 32'd0);
    check("mrst_busy",  {31'd0, busy}, 32'd0);
    repeat (3) @(negedge baud);
    #1 reset = 1'b1;
    hold(1'b1, 10);
    send(8'h5A, 1'b1, 1'b0);
    k = frame_k;
    hold(1'b1, 5);
    check("post_rst_st_cycle", last_st_cyc, k + 155);
    check("post_rst_data", {24'd0, data}, 32'h5A);

    // randomized traffic against the model
    ack_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        hold(1'b0, $urandom_range(1, 6));
        hold(1'b1, $urandom_range(12, 20));
      end else if ($urandom_range(0, 7) == 0) begin
        send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        hold(1'b0, $urandom_range(0, 30));
        hold(1'b1, $urandom_range(1, 10));
      end else begin
        send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        hold(1'b1, $urandom_range(0, 20));
      end
    end
    ack_rand = 1'b0;
    hold(1'b1, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
